// File: rtl/debounce_bank.sv
// debounce_bank: N-channel button conditioner (2-FF sync, hysteretic integrator, edge strobes).
// Define DEBOUNCE_LONG_PRESS_EN to build the per-channel long_press hold counters.
module debounce_bank #(
    parameter int N           = 4,
    parameter int MAX_COUNT   = 1000000,
    parameter int ON_THRESH   = 800000,
    parameter int OFF_THRESH  = 200000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long_press
);

    localparam int CW = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_COUNT);
    localparam logic [CW-1:0] ON_C    = CW'(ON_THRESH);
    localparam logic [CW-1:0] OFF_C   = CW'(OFF_THRESH);

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
`endif

    typedef enum logic {LOW = 1'b0, HIGH = 1'b1} level_state_t;

    if (!(OFF_THRESH < ON_THRESH && ON_THRESH <= MAX_COUNT && LONG_CYCLES > 0)) begin : g_param_check
        $error("debounce_bank: need OFF_THRESH < ON_THRESH <= MAX_COUNT and LONG_CYCLES > 0");
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          ff1, ff2;
        logic [CW-1:0] cnt;
        level_state_t  state, state_next;
        logic          rise_q, fall_q;

        // NOTE: ff1 may go metastable; only ff2 is ever allowed to reach the integrator.
        always_ff @(posedge clk) begin
            if (rst) begin
                ff1 <= 1'b0;
                ff2 <= 1'b0;
                cnt <= '0;
            end else begin
                ff1 <= btn[i];
                ff2 <= ff1;
                if (ff2 && cnt != CNT_MAX)
                    cnt <= cnt + CW'(1);
                else if (!ff2 && cnt != '0)
                    cnt <= cnt - CW'(1);
            end
        end

        // NOTE: next state gets a default first so no path through this block infers a latch.
        always_comb begin
            state_next = state;
            case (state)
                LOW:  if (cnt >= ON_C)  state_next = HIGH;
                HIGH: if (cnt <= OFF_C) state_next = LOW;
            endcase
        end

        // Strobes are registered alongside the state, so they line up with the level change.
        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= LOW;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                state  <= state_next;
                rise_q <= (state == LOW)  && (state_next == HIGH);
                fall_q <= (state == HIGH) && (state_next == LOW);
            end
        end

        assign level[i] = (state == HIGH);
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
        logic [HW-1:0] hold;
        logic          long_q;

        // hold saturates at HOLD_MAX, which is what limits long_press to one pulse per press.
        always_ff @(posedge clk) begin
            if (rst) begin
                hold   <= '0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (state != HIGH) begin
                    hold <= '0;
                end else if (hold != HOLD_MAX) begin
                    hold   <= hold + HW'(1);
                    long_q <= (hold == HOLD_MAX - HW'(1));
                end
            end
        end

        assign long_press[i] = long_q;
`else
        assign long_press[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenarios plus random bounce, checked against a cycle model
// of the integrate/threshold rules. Honours DEBOUNCE_LONG_PRESS_EN like the design.
module tb_debounce_bank;

    localparam int N           = 4;
    localparam int MAX_COUNT   = 15;
    localparam int ON_THRESH   = 12;
    localparam int OFF_THRESH  = 3;
    localparam int LONG_CYCLES = 40;
    localparam int RISE_LAT    = ON_THRESH + 3;
    localparam int FALL_LAT    = MAX_COUNT - OFF_THRESH + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '1;
    logic [N-1:0] level, rise, fall, long_press;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .N(N), .MAX_COUNT(MAX_COUNT), .ON_THRESH(ON_THRESH),
        .OFF_THRESH(OFF_THRESH), .LONG_CYCLES(LONG_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .level(level), .rise(rise), .fall(fall), .long_press(long_press)
    );

    // Reference model: button seen two edges late, saturating integer count, threshold
    // hysteresis on the previous count, and a count of cycles spent high.
    int           m_cnt  [N] = '{default: 0};
    int           m_hold [N] = '{default: 0};
    logic [N-1:0] m_d1 = '0, m_d2 = '0;
    logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_long = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = '{default: 0};
            m_hold = '{default: 0};
            m_d1 = '0; m_d2 = '0;
            m_level = '0; m_rise = '0; m_fall = '0; m_long = '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                automatic logic was = m_level[c];
                automatic logic nxt = was;
                if (!was && m_cnt[c] >= ON_THRESH) nxt = 1'b1;
                else if (was && m_cnt[c] <= OFF_THRESH) nxt = 1'b0;
                m_rise[c] = nxt & ~was;
                m_fall[c] = was & ~nxt;
`ifdef DEBOUNCE_LONG_PRESS_EN
                m_long[c] = was && (m_hold[c] == LONG_CYCLES - 1);
                m_hold[c] = was ? ((m_hold[c] < LONG_CYCLES) ? m_hold[c] + 1 : m_hold[c]) : 0;
`else
                m_long[c] = 1'b0;
`endif
                m_level[c] = nxt;
                if (m_d2[c]) m_cnt[c] = (m_cnt[c] < MAX_COUNT) ? m_cnt[c] + 1 : m_cnt[c];
                else         m_cnt[c] = (m_cnt[c] > 0) ? m_cnt[c] - 1 : 0;
                m_d2[c] = m_d1[c];
                m_d1[c] = btn[c];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({level, rise, fall, long_press} !== '0) begin
            errors++;
            $display("FAIL reset_hold: l/r/f/lp=%h/%h/%h/%h want all 0", level, rise, fall, long_press);
        end
        rst = 1'b0;
        btn = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({level, rise, fall, long_press} !== '0) begin
                errors++;
                $display("FAIL reset_exit cyc %0d: l/r/f/lp=%h/%h/%h/%h want all 0",
                         k, level, rise, fall, long_press);
            end
        end
    endtask

    task automatic test_rise_latency();
        btn[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (level[0] !== (k >= RISE_LAT) || rise[0] !== (k == RISE_LAT)) begin
                errors++;
                $display("FAIL rise_latency cyc %0d: level0=%b rise0=%b want %b/%b",
                         k, level[0], rise[0], k >= RISE_LAT, k == RISE_LAT);
            end
            checks++;
            if ({level[3:1], rise[3:1], fall, long_press} !== '0) begin
                errors++;
                $display("FAIL rise_other_ch cyc %0d: level=%h rise=%h fall=%h want ch1-3 quiet",
                         k, level, rise, fall);
            end
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 60; k++) begin
            btn[1] = ((k / 2) % 2) == 1;
            tick();
            checks++;
            if (level[1] !== 1'b0 || rise[1] !== 1'b0) begin
                errors++;
                $display("FAIL bounce cyc %0d: level1=%b rise1=%b want 0/0", k, level[1], rise[1]);
            end
        end
        btn[1] = 1'b0;
        repeat (12) tick();
        checks++;
        if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
            errors++;
            $display("FAIL bounce_model: l/r/f=%h/%h/%h want %h/%h/%h",
                     level, rise, fall, m_level, m_rise, m_fall);
        end
    endtask

    task automatic test_glitch_release();
        btn[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (level[0] !== 1'b1 || fall[0] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_hold cyc %0d: level0=%b fall0=%b want 1/0", k, level[0], fall[0]);
            end
        end
        btn[0] = 1'b1;
        repeat (20) tick();
        btn[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (level[0] !== (k < FALL_LAT) || fall[0] !== (k == FALL_LAT)) begin
                errors++;
                $display("FAIL release_latency cyc %0d: level0=%b fall0=%b want %b/%b",
                         k, level[0], fall[0], k < FALL_LAT, k == FALL_LAT);
            end
        end
    endtask

    task automatic test_all_channels();
        btn = '1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (rise !== ((k == RISE_LAT) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL all_rise cyc %0d: rise=%h want %h", k, rise, (k == RISE_LAT) ? 4'hF : 4'h0);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        btn = '0;
        checks++;
        if (level !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_press: level=%h fall=%h want 0/0", level, fall);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (level !== 4'h0 || fall !== 4'h0 || rise !== 4'h0) begin
                errors++;
                $display("FAIL after_reset cyc %0d: l/r/f=%h/%h/%h want 0", k, level, rise, fall);
            end
        end
    endtask

    task automatic test_long_press();
        logic exp_lp;
        btn[2] = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            tick();
`ifdef DEBOUNCE_LONG_PRESS_EN
            exp_lp = (k == RISE_LAT + LONG_CYCLES);
`else
            exp_lp = 1'b0;
`endif
            checks++;
            if (long_press !== {1'b0, exp_lp, 2'b00}) begin
                errors++;
                $display("FAIL long_press cyc %0d: long_press=%h want %h", k, long_press, {1'b0, exp_lp, 2'b00});
            end
        end
        btn[2] = 1'b0;
        repeat (25) tick();
        checks++;
        if ({level, long_press} !== {m_level, m_long}) begin
            errors++;
            $display("FAIL long_release: level=%h lp=%h want %h/%h", level, long_press, m_level, m_long);
        end
    endtask

    task automatic test_random();
        int left [N] = '{default: 0};
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N; c++) begin
                if (left[c] == 0) begin
                    btn[c]  = 1'($urandom_range(0, 1));
                    left[c] = $urandom_range(1, 24);
                end
                left[c]--;
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if ({level, rise, fall, long_press} !== {m_level, m_rise, m_fall, m_long}) begin
                errors++;
                $display("FAIL random cyc %0d: l/r/f/lp=%h/%h/%h/%h want %h/%h/%h/%h", k,
                         level, rise, fall, long_press, m_level, m_rise, m_fall, m_long);
            end
            checks++;
            if ((rise & fall) !== '0) begin
                errors++;
                $display("FAIL rise_and_fall cyc %0d: rise=%h fall=%h want disjoint", k, rise, fall);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_bounce();
        test_glitch_release();
        test_all_channels();
        test_long_press();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
